// File: rtl/ins_fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared field widths and the decoded instruction word type
//                for the dual-issue fetch/decode buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int OP_W   = 4;
    localparam int DES_W  = 4;
    localparam int S1_W   = 4;
    localparam int S2_W   = 4;
    localparam int IME_W  = 5;
    // Raw word width is always the sum of the fields; never overridden.
    localparam int WORD_W = OP_W + DES_W + S1_W + S2_W + IME_W;

    // Field order matches the raw word layout, MSB to LSB.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [DES_W-1:0] des;
        logic [S1_W-1:0]  s1;
        logic [S2_W-1:0]  s2;
        logic [IME_W-1:0] ime;
    } ins_word_t;

endpackage
`default_nettype wire

// File: rtl/ins_fetch_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ins_fetch_buffer_if
//  Description : Fetch-side and queue-side handshake bundle of the fetch
//                buffer. The slave modport is the buffer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface ins_fetch_buffer_if
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // fetch side
    logic              fetch_1_vld;
    logic [WORD_W-1:0] fetch_1_word;
    logic              fetch_2_vld;
    logic [WORD_W-1:0] fetch_2_word;
    logic              fetch_rdy;

    // queue side
    logic              entry_full;
    logic              flush_en;
    logic              ins_new_1_vld;
    logic [OP_W-1:0]   ins_1_op;
    logic [DES_W-1:0]  ins_1_des;
    logic [S1_W-1:0]   ins_1_s1;
    logic [S2_W-1:0]   ins_1_s2;
    logic [IME_W-1:0]  ins_1_ime;
    logic              ins_new_2_vld;
    logic [OP_W-1:0]   ins_2_op;
    logic [DES_W-1:0]  ins_2_des;
    logic [S1_W-1:0]   ins_2_s1;
    logic [S2_W-1:0]   ins_2_s2;
    logic [IME_W-1:0]  ins_2_ime;
    logic [CNT_W-1:0]  buf_count;

    modport master (
        output fetch_1_vld, fetch_1_word, fetch_2_vld, fetch_2_word,
        output entry_full, flush_en,
        input  fetch_rdy,
        input  ins_new_1_vld, ins_1_op, ins_1_des, ins_1_s1, ins_1_s2, ins_1_ime,
        input  ins_new_2_vld, ins_2_op, ins_2_des, ins_2_s1, ins_2_s2, ins_2_ime,
        input  buf_count
    );

    modport slave (
        input  fetch_1_vld, fetch_1_word, fetch_2_vld, fetch_2_word,
        input  entry_full, flush_en,
        output fetch_rdy,
        output ins_new_1_vld, ins_1_op, ins_1_des, ins_1_s1, ins_1_s2, ins_1_ime,
        output ins_new_2_vld, ins_2_op, ins_2_des, ins_2_s1, ins_2_s2, ins_2_ime,
        output buf_count
    );

endinterface
`default_nettype wire

// File: rtl/ins_fetch_buffer_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ins_field_decode
//  Description : Splits a raw instruction word into its named fields.
//  Revision    : 1.0  initial release
// ============================================================================
module ins_field_decode
    import fetch_pkg::*;
(
    input  wire logic [WORD_W-1:0] i_word,
    output ins_word_t              o_fields
);

    // Pure field split; the struct layout mirrors the raw word layout.
    always_comb begin
        o_fields = ins_word_t'(i_word);
    end

endmodule
`default_nettype wire

// File: rtl/ins_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ins_fetch_buffer
//  Description : Dual-issue circular fetch/decode buffer. Takes up to two
//                raw words per cycle from fetch and presents up to two
//                decoded instructions per cycle to the instruction queue.
//  Revision    : 1.0  initial release
// ============================================================================
module ins_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  wire logic         clk,
    input  wire logic         rst,
    ins_fetch_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage holds no reset: stale slots are hidden by the valid gating.
    ins_word_t        r_mem [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr_q;
    logic [PTR_W-1:0] w_rd_ptr_d;
    logic [PTR_W-1:0] r_wr_ptr_q;
    logic [PTR_W-1:0] w_wr_ptr_d;
    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    logic             w_fetch_rdy;
    logic             w_push_1;
    logic             w_push_2;
    logic [1:0]       w_n_push;
    logic [1:0]       w_n_pop;
    logic [PTR_W-1:0] w_wr_ptr_p1;
    logic [PTR_W-1:0] w_rd_ptr_p1;
    ins_word_t        w_head_word;
    ins_word_t        w_next_word;
    ins_word_t        w_head_dec;
    ins_word_t        w_next_dec;

    // Push/pop decisions and next-state of pointers and occupancy.
    always_comb begin
        w_fetch_rdy = 1'b0;
        w_push_1    = 1'b0;
        w_push_2    = 1'b0;
        w_n_push    = 2'd0;
        w_n_pop     = 2'd0;
        w_rd_ptr_d  = r_rd_ptr_q;
        w_wr_ptr_d  = r_wr_ptr_q;
        w_count_d   = r_count_q;
        w_wr_ptr_p1 = r_wr_ptr_q + PTR_W'(1);
        w_rd_ptr_p1 = r_rd_ptr_q + PTR_W'(1);

        // Ready depends only on the registered count, so fetch never sees
        // a combinational path from the queue or the flush line.
        w_fetch_rdy = !rst && (r_count_q <= CNT_W'(DEPTH - 2));

        // Word 2 is only meaningful alongside word 1; a flush drops both.
        w_push_1 = bus.fetch_1_vld && w_fetch_rdy && !bus.flush_en;
        w_push_2 = w_push_1 && bus.fetch_2_vld;
        w_n_push = {1'b0, w_push_1} + {1'b0, w_push_2};

        if (rst || bus.flush_en || bus.entry_full) begin
            w_n_pop = 2'd0;
        end else if (r_count_q >= CNT_W'(2)) begin
            w_n_pop = 2'd2;
        end else begin
            w_n_pop = r_count_q[1:0];
        end

        w_rd_ptr_d = r_rd_ptr_q + PTR_W'(w_n_pop);
        w_wr_ptr_d = r_wr_ptr_q + PTR_W'(w_n_push);
        w_count_d  = r_count_q + CNT_W'(w_n_push) - CNT_W'(w_n_pop);

        // Everything buffered is younger than the mispredicted branch.
        if (bus.flush_en) begin
            w_rd_ptr_d = '0;
            w_wr_ptr_d = '0;
            w_count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr_q <= '0;
            r_wr_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Write accepted fetch words into consecutive slots.
    always_ff @(posedge clk) begin
        if (w_push_1) begin
            r_mem[r_wr_ptr_q] <= ins_word_t'(bus.fetch_1_word);
        end
        if (w_push_2) begin
            r_mem[w_wr_ptr_p1] <= ins_word_t'(bus.fetch_2_word);
        end
    end

    assign w_head_word = r_mem[r_rd_ptr_q];
    assign w_next_word = r_mem[w_rd_ptr_p1];

    ins_field_decode u_dec_head (
        .i_word   (w_head_word),
        .o_fields (w_head_dec)
    );

    ins_field_decode u_dec_next (
        .i_word   (w_next_word),
        .o_fields (w_next_dec)
    );

    assign bus.fetch_rdy     = w_fetch_rdy;
    assign bus.ins_new_1_vld = (w_n_pop != 2'd0);
    assign bus.ins_new_2_vld = (w_n_pop == 2'd2);
    assign bus.ins_1_op      = w_head_dec.op;
    assign bus.ins_1_des     = w_head_dec.des;
    assign bus.ins_1_s1      = w_head_dec.s1;
    assign bus.ins_1_s2      = w_head_dec.s2;
    assign bus.ins_1_ime     = w_head_dec.ime;
    assign bus.ins_2_op      = w_next_dec.op;
    assign bus.ins_2_des     = w_next_dec.des;
    assign bus.ins_2_s1      = w_next_dec.s1;
    assign bus.ins_2_s2      = w_next_dec.s2;
    assign bus.ins_2_ime     = w_next_dec.ime;
    assign bus.buf_count     = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ins_fetch_buffer
//  Description : Directed self-checking bench for ins_fetch_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ins_fetch_buffer;
    import fetch_pkg::*;

    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n;
    logic [WORD_W-1:0] sb [$];

    ins_fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    ins_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WORD_W-1:0] mk(int op, int des, int s1, int s2, int ime);
        return {4'(op), 4'(des), 4'(s1), 4'(s2), 5'(ime)};
    endfunction

    function automatic logic [WORD_W-1:0] gen(int k);
        return {4'(k), 4'(k + 3), 4'(k + 5), 4'(k + 7), 5'(k + 11)};
    endfunction

    function automatic logic [WORD_W-1:0] out1();
        return {bus.ins_1_op, bus.ins_1_des, bus.ins_1_s1, bus.ins_1_s2, bus.ins_1_ime};
    endfunction

    function automatic logic [WORD_W-1:0] out2();
        return {bus.ins_2_op, bus.ins_2_des, bus.ins_2_s1, bus.ins_2_s2, bus.ins_2_ime};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_off();
        bus.fetch_1_vld  = 1'b0;
        bus.fetch_2_vld  = 1'b0;
        bus.fetch_1_word = '0;
        bus.fetch_2_word = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_off();
        bus.entry_full = 1'b0;
        bus.flush_en   = 1'b0;
        tick();
        checks++; if (bus.fetch_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", bus.fetch_rdy); end
        checks++; if (bus.ins_new_1_vld !== 1'b0 || bus.ins_new_2_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b%b exp=00", bus.ins_new_1_vld, bus.ins_new_2_vld); end
        rst = 1'b0;
        #1;
        checks++; if (bus.buf_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.buf_count); end
        checks++; if (bus.fetch_rdy !== 1'b1) begin errors++; $display("FAIL empty_rdy got=%b exp=1", bus.fetch_rdy); end
        checks++; if (bus.ins_new_1_vld !== 1'b0) begin errors++; $display("FAIL empty_vld got=%b exp=0", bus.ins_new_1_vld); end
    endtask

    task automatic test_basic();
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        a = mk(3, 1, 2, 4, 5);
        b = mk(7, 9, 1, 3, 6);
        bus.fetch_1_vld = 1'b1; bus.fetch_1_word = a;
        bus.fetch_2_vld = 1'b1; bus.fetch_2_word = b;
        #1;
        checks++; if (bus.ins_new_1_vld !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got=%b exp=0", bus.ins_new_1_vld); end
        tick();
        fetch_off();
        #1;
        checks++; if (bus.buf_count !== 4'd2) begin errors++; $display("FAIL basic_count got=%0d exp=2", bus.buf_count); end
        checks++; if (bus.ins_new_1_vld !== 1'b1 || bus.ins_new_2_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got=%b%b exp=11", bus.ins_new_1_vld, bus.ins_new_2_vld); end
        checks++; if (bus.ins_1_op !== 4'd3 || bus.ins_1_des !== 4'd1 || bus.ins_1_s1 !== 4'd2 || bus.ins_1_s2 !== 4'd4 || bus.ins_1_ime !== 5'd5) begin errors++; $display("FAIL basic_ins1 got=%h exp=%h", out1(), a); end
        checks++; if (out2() !== b) begin errors++; $display("FAIL basic_ins2 got=%h exp=%h", out2(), b); end
        tick();
        checks++; if (bus.buf_count !== 4'd0) begin errors++; $display("FAIL basic_drain got=%0d exp=0", bus.buf_count); end
    endtask

    task automatic test_fill();
        sb.delete();
        n = 0;
        bus.entry_full = 1'b1;
        for (int j = 0; j < 4; j++) begin
            bus.fetch_1_vld = 1'b1; bus.fetch_1_word = gen(n);
            bus.fetch_2_vld = 1'b1; bus.fetch_2_word = gen(n + 1);
            #1;
            checks++; if (bus.fetch_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy step=%0d got=%b exp=1", j, bus.fetch_rdy); end
            checks++; if (bus.ins_new_1_vld !== 1'b0) begin errors++; $display("FAIL fill_hold_vld step=%0d got=%b exp=0", j, bus.ins_new_1_vld); end
            tick();
            sb.push_back(gen(n));
            sb.push_back(gen(n + 1));
            n += 2;
        end
        #1;
        checks++; if (bus.buf_count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", bus.buf_count); end
        checks++; if (bus.fetch_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got=%b exp=0", bus.fetch_rdy); end
        tick();
        checks++; if (bus.buf_count !== 4'd8) begin errors++; $display("FAIL full_not_taken got=%0d exp=8", bus.buf_count); end
        fetch_off();
        bus.entry_full = 1'b0;
        #1;
        checks++; if (bus.ins_new_1_vld !== 1'b1 || bus.ins_new_2_vld !== 1'b1) begin errors++; $display("FAIL release_vld got=%b%b exp=11", bus.ins_new_1_vld, bus.ins_new_2_vld); end
        checks++; if (out1() !== sb[0] || out2() !== sb[1]) begin errors++; $display("FAIL release_order got=%h,%h exp=%h,%h", out1(), out2(), sb[0], sb[1]); end
        tick();
        void'(sb.pop_front());
        void'(sb.pop_front());
        checks++; if (bus.buf_count !== 4'd6) begin errors++; $display("FAIL release_count got=%0d exp=6", bus.buf_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            bus.fetch_1_vld = 1'b1; bus.fetch_1_word = gen(n);
            bus.fetch_2_vld = 1'b1; bus.fetch_2_word = gen(n + 1);
            #1;
            checks++; if (bus.fetch_rdy !== 1'b1 || bus.ins_new_1_vld !== 1'b1 || bus.ins_new_2_vld !== 1'b1) begin errors++; $display("FAIL b2b_hs it=%0d got rdy=%b vld=%b%b exp 1 11", i, bus.fetch_rdy, bus.ins_new_1_vld, bus.ins_new_2_vld); end
            checks++; if (out1() !== sb[0] || out2() !== sb[1]) begin errors++; $display("FAIL b2b_order it=%0d got=%h,%h exp=%h,%h", i, out1(), out2(), sb[0], sb[1]); end
            tick();
            void'(sb.pop_front());
            void'(sb.pop_front());
            sb.push_back(gen(n));
            sb.push_back(gen(n + 1));
            n += 2;
            checks++; if (bus.buf_count !== 4'd6) begin errors++; $display("FAIL b2b_count it=%0d got=%0d exp=6", i, bus.buf_count); end
        end
        fetch_off();
    endtask

    task automatic test_count7();
        bus.entry_full  = 1'b1;
        bus.fetch_1_vld = 1'b1; bus.fetch_1_word = gen(n);
        tick();
        sb.push_back(gen(n));
        n++;
        checks++; if (bus.buf_count !== 4'd7 || bus.fetch_rdy !== 1'b0) begin errors++; $display("FAIL c7_state got count=%0d rdy=%b exp 7 0", bus.buf_count, bus.fetch_rdy); end
        bus.fetch_1_word = gen(n);
        bus.fetch_2_vld  = 1'b1; bus.fetch_2_word = gen(n + 1);
        tick();
        checks++; if (bus.buf_count !== 4'd7) begin errors++; $display("FAIL c7_hold got=%0d exp=7", bus.buf_count); end
        fetch_off();
        bus.entry_full = 1'b0;
        #1;
        checks++; if (out1() !== sb[0] || out2() !== sb[1] || bus.ins_new_2_vld !== 1'b1) begin errors++; $display("FAIL c7_drain got=%h,%h exp=%h,%h", out1(), out2(), sb[0], sb[1]); end
        tick();
        void'(sb.pop_front());
        void'(sb.pop_front());
        checks++; if (bus.buf_count !== 4'd5) begin errors++; $display("FAIL c7_count got=%0d exp=5", bus.buf_count); end
    endtask

    task automatic test_flush();
        bus.flush_en    = 1'b1;
        bus.entry_full  = 1'b0;
        bus.fetch_1_vld = 1'b1; bus.fetch_1_word = mk(15, 15, 15, 15, 31);
        bus.fetch_2_vld = 1'b1; bus.fetch_2_word = mk(14, 14, 14, 14, 30);
        #1;
        checks++; if (bus.ins_new_1_vld !== 1'b0 || bus.ins_new_2_vld !== 1'b0) begin errors++; $display("FAIL flush_vld got=%b%b exp=00", bus.ins_new_1_vld, bus.ins_new_2_vld); end
        tick();
        bus.flush_en = 1'b0;
        fetch_off();
        #1;
        sb.delete();
        checks++; if (bus.buf_count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.buf_count); end
        checks++; if (bus.ins_new_1_vld !== 1'b0 || bus.fetch_rdy !== 1'b1) begin errors++; $display("FAIL flush_empty got vld=%b rdy=%b exp 0 1", bus.ins_new_1_vld, bus.fetch_rdy); end
    endtask

    task automatic test_fetch2_only();
        logic [WORD_W-1:0] z;
        z = mk(10, 2, 3, 4, 6);
        bus.entry_full  = 1'b1;
        bus.fetch_2_vld = 1'b1; bus.fetch_2_word = mk(9, 9, 9, 9, 9);
        tick();
        checks++; if (bus.buf_count !== 4'd0) begin errors++; $display("FAIL f2only_count got=%0d exp=0", bus.buf_count); end
        fetch_off();
        bus.fetch_1_vld = 1'b1; bus.fetch_1_word = z;
        tick();
        fetch_off();
        bus.entry_full = 1'b0;
        #1;
        checks++; if (bus.buf_count !== 4'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", bus.buf_count); end
        checks++; if (bus.ins_new_1_vld !== 1'b1 || bus.ins_new_2_vld !== 1'b0) begin errors++; $display("FAIL single_vld got=%b%b exp=10", bus.ins_new_1_vld, bus.ins_new_2_vld); end
        checks++; if (out1() !== z) begin errors++; $display("FAIL single_word got=%h exp=%h", out1(), z); end
        tick();
        checks++; if (bus.buf_count !== 4'd0) begin errors++; $display("FAIL single_drain got=%0d exp=0", bus.buf_count); end
    endtask

    task automatic test_reset_mid();
        logic [WORD_W-1:0] w;
        w = mk(5, 6, 7, 8, 19);
        bus.entry_full = 1'b1;
        for (int j = 0; j < 2; j++) begin
            bus.fetch_1_vld = 1'b1; bus.fetch_1_word = gen(40 + 2 * j);
            bus.fetch_2_vld = 1'b1; bus.fetch_2_word = gen(41 + 2 * j);
            tick();
        end
        fetch_off();
        checks++; if (bus.buf_count !== 4'd4) begin errors++; $display("FAIL rmid_count got=%0d exp=4", bus.buf_count); end
        bus.entry_full = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.fetch_rdy !== 1'b0 || bus.ins_new_1_vld !== 1'b0 || bus.ins_new_2_vld !== 1'b0) begin errors++; $display("FAIL rmid_during got rdy=%b vld=%b%b exp 0 00", bus.fetch_rdy, bus.ins_new_1_vld, bus.ins_new_2_vld); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.buf_count !== 4'd0 || bus.fetch_rdy !== 1'b1) begin errors++; $display("FAIL rmid_after got count=%0d rdy=%b exp 0 1", bus.buf_count, bus.fetch_rdy); end
        bus.fetch_1_vld = 1'b1; bus.fetch_1_word = w;
        tick();
        fetch_off();
        #1;
        checks++; if (bus.ins_new_1_vld !== 1'b1 || bus.ins_new_2_vld !== 1'b0 || out1() !== w) begin errors++; $display("FAIL rmid_first got vld=%b%b word=%h exp 10 %h", bus.ins_new_1_vld, bus.ins_new_2_vld, out1(), w); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.entry_full = 1'b0;
        bus.flush_en   = 1'b0;
        fetch_off();
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_count7();
        test_flush();
        test_fetch2_only();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
